// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and types for the writeback stage
package rv_pkg;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One pending register write: destination index plus final data
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO holding aligned load results
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; a simultaneous push and pop keeps the count
    always_comb begin
        wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset drops all queued entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage merging ALU and load results into one write port
module wb_stage
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RD_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [RD_W-1:0] mem_rd,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [RD_W-1:0] WNUM,
    output logic [XLEN-1:0] WDATA,
    output logic            busy
);

    logic [RD_W-1:0] wnum_q, wnum_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic            alu_acc, load_keep;
    wb_entry_t       load_entry, head_entry;

    // Select the addressed byte/halfword lane and extend it to XLEN
    function automatic logic [XLEN-1:0] align_load(input logic [2:0]      f3,
                                                   input logic [1:0]      lo,
                                                   input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'd0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'd0, h};
            F3_LW:   return word;
            default: return '0;
        endcase
    endfunction

    assign alu_ready       = !fifo_full;
    assign mem_ready       = !fifo_full;
    assign busy            = !fifo_empty;
    assign alu_acc         = alu_valid && !fifo_full;
    // Loads targeting x0 are swallowed at the handshake and never take a slot
    assign load_keep       = mem_valid && !fifo_full && (mem_rd != '0);
    assign load_entry.rd   = mem_rd;
    assign load_entry.data = align_load(mem_funct3, mem_addr_lo, mem_rdata);

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (load_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-slot arbiter: full FIFO drains first, then ALU, then queued loads, then bypass
    always_comb begin
        wnum_d    = '0;
        wdata_d   = wdata_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (fifo_full) begin
            fifo_pop = 1'b1;
            wnum_d   = head_entry.rd;
            wdata_d  = head_entry.data;
        end else if (alu_acc) begin
            wnum_d    = alu_rd;
            wdata_d   = alu_data;
            fifo_push = load_keep;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            wnum_d    = head_entry.rd;
            wdata_d   = head_entry.data;
            fifo_push = load_keep;
        end else if (load_keep) begin
            wnum_d  = load_entry.rd;
            wdata_d = load_entry.data;
        end
    end

    // Registered write port; reset clears any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
        end
    end

    assign WNUM  = wnum_q;
    assign WDATA = wdata_q;

endmodule
